regfile: RTL and testbench
==========================

// Module: regfile
// PURPOSE
//  MIPS general-purpose register file serving the ID stage's two read requests (rs/rt) and the WB-stage write.
//  - 32 x 32-bit registers; $0 reads as zero.
//  - Per-register pending-write scoreboard: ID reserves a destination at dispatch, WB releases it on write-back.
//  - Flags reads of not-yet-written operands so the pipeline controller can stall ID.
// PARAMETERS
//  PEND_W  2  width of per-register pending-write counter (max in flight = 2**PEND_W-1 = 3)
// PORTS
//  clk            in   1   clock; all state updates on rising edge
//  rst            in   1   synchronous reset, active-high
//  reg1_read_i    in   1   ID port 1 read enable
//  reg1_addr_i    in   5   ID port 1 address (rs)
//  reg2_read_i    in   1   ID port 2 read enable
//  reg2_addr_i    in   5   ID port 2 address (rt)
//  reg1_data_o    out  32  port 1 read data
//  reg2_data_o    out  32  port 2 read data
//  reg1_busy_o    out  1   port 1 operand has an outstanding write
//  reg2_busy_o    out  1   port 2 operand has an outstanding write
//  stall_o        out  1   reg1_busy_o | reg2_busy_o
//  issue_valid_i  in   1   ID dispatches an instruction that writes issue_addr_i
//  issue_addr_i   in   5   destination being reserved
//  issue_ready_o  out  1   reservation can be accepted this cycle
//  wb_we_i        in   1   WB write enable
//  wb_addr_i      in   5   WB write address
//  wb_data_i      in   32  WB write data
//  err_o          out  1   sticky: WB write to a register with zero pending count
// BEHAVIOUR
//  Reset (rst=1 at posedge): all 32 registers <= 0, all pending counters <= 0, err_o <= 0.
//   While rst=1: reg*_data_o=0, reg*_busy_o=0, stall_o=0, issue_ready_o=0 (combinational override).
//  Read: combinational, zero latency. readN_i=0 or addrN=0 -> dataN_o=0, busyN_o=0.
//   Otherwise dataN_o = regs[addrN]; busyN_o = (pend[addrN] != 0) after the bypass rule below.
//  Write: wb_we_i=1 & wb_addr_i!=0 -> regs[wb_addr_i] <= wb_data_i at posedge. Writes to $0 are dropped.
//   A write to $0 never touches counters or err_o.
//  Issue handshake: reservation accepted iff issue_valid_i & issue_ready_o at the posedge.
//   issue_ready_o = (issue_addr_i==0) | (pend[issue_addr_i] != 2**PEND_W-1) | retire to same addr this cycle.
//   Accepted, addr!=0 -> pend[addr]+1. addr=0 -> accepted, no state change.
//   ID must hold issue_valid_i/issue_addr_i until accepted.
//  Retire: wb_we_i & wb_addr_i!=0 -> pend[wb_addr_i]-1.
//   If pend already 0 -> pend stays 0, err_o <= 1 (sticky until reset).
//  Simultaneous accepted issue and retire to the same addr: pend unchanged.
//   Write data is still committed. No err_o when pend was 0 (net 0 -> 0 is legal only in this case).
//  Issue and retire to different addrs in one cycle: both counters update independently.
//  Both read ports may address the same register; each resolves independently.
//  A read of the register being reserved this cycle sees the pre-reservation count (reservation lands next cycle).
//  Counter width arithmetic: unsigned PEND_W bits, never wraps (saturation guarded by issue_ready_o and the err_o rule).
// CONFIGURATION
//  REGFILE_BYPASS_EN defined:
//   - read address == wb_addr_i with wb_we_i=1 (addr!=0) -> dataN_o = wb_data_i (same-cycle write-through).
//   - busyN_o = (pend[addrN] > 1) in that case, i.e. the retiring write is treated as already complete.
//  REGFILE_BYPASS_EN undefined:
//   - reads return the stored value only; new data is visible the cycle after the write.
//   - busyN_o uses the unmodified pend[addrN].
// TESTING
//  Reset: rst=1 for 2 cycles after random writes -> all reads 0, busy 0, err_o 0, issue_ready_o 0 during rst.
//  Write/read: wb write $5=0xDEADBEEF; next cycle read1=$5 -> 0xDEADBEEF.
//   Wb write $0=0x1234 -> read $0 = 0 and err_o stays 0.
//  Scoreboard: issue $8 three times -> 4th issue to $8 gets issue_ready_o=0.
//   One retire of $8 -> ready=1; read $8 busy=1 until all three retired, then busy=0, stall_o=0.
//  Bypass (EN): pend[$3]=1, same cycle wb $3=0xA5A5A5A5 and read2=$3 -> data 0xA5A5A5A5, busy 0.
//   Without EN -> old value, busy 1, new value next cycle.
//  Collision: pend[$9]=1, issue $9 and retire $9 same cycle -> pend[$9] stays 1 (busy=1 next cycle), data committed.
//  Error/reset mid-op: retire $10 with pend 0 -> err_o=1 and sticks.
//   Assert rst with pend[$4]=2 -> next cycle err_o=0, pend 0, read $4 = 0, busy 0.

Source files
------------

// File: rtl/regfile.sv
// MIPS 32x32 register file with per-register pending-write scoreboard.
// Define REGFILE_BYPASS_EN for same-cycle WB write-through on reads.
module regfile #(
  parameter int PEND_W = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        reg1_read_i,
  input  logic [4:0]  reg1_addr_i,
  input  logic        reg2_read_i,
  input  logic [4:0]  reg2_addr_i,
  output logic [31:0] reg1_data_o,
  output logic [31:0] reg2_data_o,
  output logic        reg1_busy_o,
  output logic        reg2_busy_o,
  output logic        stall_o,
  input  logic        issue_valid_i,
  input  logic [4:0]  issue_addr_i,
  output logic        issue_ready_o,
  input  logic        wb_we_i,
  input  logic [4:0]  wb_addr_i,
  input  logic [31:0] wb_data_i,
  output logic        err_o
);

  localparam logic [PEND_W-1:0] PEND_MAX = '1;
  localparam logic [PEND_W-1:0] PEND_ONE = PEND_W'(1);

  logic [31:0]       regs [32];
  logic [PEND_W-1:0] pend [32];
  logic              err_q;
  logic              retire;
  logic              same_addr;
  logic              accept;

  assign retire    = wb_we_i && (wb_addr_i != 5'd0);
  assign same_addr = retire && (wb_addr_i == issue_addr_i);

  assign issue_ready_o = !rst &&
    ((issue_addr_i == 5'd0) ||
     (pend[issue_addr_i] != PEND_MAX) ||
     same_addr);

  assign accept = issue_valid_i && issue_ready_o &&
                  (issue_addr_i != 5'd0);

  // Reserve and release on the same register cancel out.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 32; i++) begin
        regs[i] <= '0;
        pend[i] <= '0;
      end
      err_q <= 1'b0;
    end else begin
      if (retire)
        regs[wb_addr_i] <= wb_data_i;
      if (accept && !same_addr)
        pend[issue_addr_i] <= pend[issue_addr_i] + PEND_ONE;
      if (retire && !(accept && same_addr)) begin
        if (pend[wb_addr_i] == '0)
          err_q <= 1'b1;
        else
          pend[wb_addr_i] <= pend[wb_addr_i] - PEND_ONE;
      end
    end
  end

  assign err_o = err_q;

  always_comb begin
    reg1_data_o = '0;
    reg1_busy_o = 1'b0;
    if (!rst && reg1_read_i && (reg1_addr_i != 5'd0)) begin
      reg1_data_o = regs[reg1_addr_i];
      reg1_busy_o = (pend[reg1_addr_i] != '0);
`ifdef REGFILE_BYPASS_EN
      if (retire && (wb_addr_i == reg1_addr_i)) begin
        reg1_data_o = wb_data_i;
        reg1_busy_o = (pend[reg1_addr_i] > PEND_ONE);
      end
`endif
    end
  end

  always_comb begin
    reg2_data_o = '0;
    reg2_busy_o = 1'b0;
    if (!rst && reg2_read_i && (reg2_addr_i != 5'd0)) begin
      reg2_data_o = regs[reg2_addr_i];
      reg2_busy_o = (pend[reg2_addr_i] != '0);
`ifdef REGFILE_BYPASS_EN
      if (retire && (wb_addr_i == reg2_addr_i)) begin
        reg2_data_o = wb_data_i;
        reg2_busy_o = (pend[reg2_addr_i] > PEND_ONE);
      end
`endif
    end
  end

  assign stall_o = reg1_busy_o | reg2_busy_o;

endmodule

// File: tb/tb_regfile.sv
// Directed self-checking bench for regfile.
// Bypass expectations follow REGFILE_BYPASS_EN.
module tb_regfile;

  logic        clk;
  logic        rst;
  logic        reg1_read_i;
  logic [4:0]  reg1_addr_i;
  logic        reg2_read_i;
  logic [4:0]  reg2_addr_i;
  logic [31:0] reg1_data_o;
  logic [31:0] reg2_data_o;
  logic        reg1_busy_o;
  logic        reg2_busy_o;
  logic        stall_o;
  logic        issue_valid_i;
  logic [4:0]  issue_addr_i;
  logic        issue_ready_o;
  logic        wb_we_i;
  logic [4:0]  wb_addr_i;
  logic [31:0] wb_data_i;
  logic        err_o;

  int passed = 0;
  int total  = 0;

  regfile dut (
    .clk          (clk),
    .rst          (rst),
    .reg1_read_i  (reg1_read_i),
    .reg1_addr_i  (reg1_addr_i),
    .reg2_read_i  (reg2_read_i),
    .reg2_addr_i  (reg2_addr_i),
    .reg1_data_o  (reg1_data_o),
    .reg2_data_o  (reg2_data_o),
    .reg1_busy_o  (reg1_busy_o),
    .reg2_busy_o  (reg2_busy_o),
    .stall_o      (stall_o),
    .issue_valid_i(issue_valid_i),
    .issue_addr_i (issue_addr_i),
    .issue_ready_o(issue_ready_o),
    .wb_we_i      (wb_we_i),
    .wb_addr_i    (wb_addr_i),
    .wb_data_i    (wb_data_i),
    .err_o        (err_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    cyc();
    cyc();
    rst = 1'b0;
    issue_valid_i = 1'b1;
    issue_addr_i = 5'd7;
    cyc();
    issue_valid_i = 1'b0;
    issue_addr_i = 5'd0;
    wb_we_i = 1'b1;
    wb_addr_i = 5'd7;
    wb_data_i = 32'h77;
    cyc();
    wb_addr_i = 5'd11;
    wb_data_i = 32'h1111;
    cyc();
    wb_we_i = 1'b0;
    reg1_read_i = 1'b1;
    reg1_addr_i = 5'd7;
    reg2_read_i = 1'b1;
    reg2_addr_i = 5'd11;
    #1;
    total++;
    if (reg1_data_o !== 32'h77)
      $display("FAIL pre_rst_data got %h exp %h", reg1_data_o, 32'h77);
    else passed++;
    total++;
    if (err_o !== 1'b1)
      $display("FAIL pre_rst_err got %b exp 1", err_o);
    else passed++;
    rst = 1'b1;
    #1;
    total++;
    if (issue_ready_o !== 1'b0)
      $display("FAIL rst_ready got %b exp 0", issue_ready_o);
    else passed++;
    total++;
    if (reg1_data_o !== 32'h0 || reg1_busy_o !== 1'b0)
      $display("FAIL rst_read1 got %h/%b exp 0/0",
               reg1_data_o, reg1_busy_o);
    else passed++;
    cyc();
    cyc();
    rst = 1'b0;
    #1;
    total++;
    if (reg1_data_o !== 32'h0 || reg2_data_o !== 32'h0)
      $display("FAIL post_rst_data got %h/%h exp 0/0",
               reg1_data_o, reg2_data_o);
    else passed++;
    total++;
    if (err_o !== 1'b0 || stall_o !== 1'b0)
      $display("FAIL post_rst_err got %b/%b exp 0/0", err_o, stall_o);
    else passed++;
    total++;
    if (issue_ready_o !== 1'b1)
      $display("FAIL post_rst_ready got %b exp 1", issue_ready_o);
    else passed++;
    reg2_read_i = 1'b0;
  endtask

  task automatic test_write_read();
    issue_valid_i = 1'b1;
    issue_addr_i = 5'd5;
    cyc();
    issue_valid_i = 1'b0;
    wb_we_i = 1'b1;
    wb_addr_i = 5'd5;
    wb_data_i = 32'hDEADBEEF;
    cyc();
    wb_we_i = 1'b0;
    reg1_addr_i = 5'd5;
    #1;
    total++;
    if (reg1_data_o !== 32'hDEADBEEF || reg1_busy_o !== 1'b0)
      $display("FAIL wr_rd got %h/%b exp deadbeef/0",
               reg1_data_o, reg1_busy_o);
    else passed++;
    wb_we_i = 1'b1;
    wb_addr_i = 5'd0;
    wb_data_i = 32'h1234;
    cyc();
    wb_we_i = 1'b0;
    reg1_addr_i = 5'd0;
    #1;
    total++;
    if (reg1_data_o !== 32'h0 || err_o !== 1'b0)
      $display("FAIL wr_zero got %h/%b exp 0/0", reg1_data_o, err_o);
    else passed++;
  endtask

  task automatic test_scoreboard();
    reg1_addr_i = 5'd8;
    issue_addr_i = 5'd8;
    issue_valid_i = 1'b1;
    for (int k = 0; k < 3; k++) begin
      #1;
      total++;
      if (issue_ready_o !== 1'b1)
        $display("FAIL sb_issue%0d got %b exp 1", k, issue_ready_o);
      else passed++;
      cyc();
    end
    #1;
    total++;
    if (issue_ready_o !== 1'b0)
      $display("FAIL sb_full got %b exp 0", issue_ready_o);
    else passed++;
    total++;
    if (reg1_busy_o !== 1'b1 || stall_o !== 1'b1)
      $display("FAIL sb_busy3 got %b/%b exp 1/1", reg1_busy_o, stall_o);
    else passed++;
    issue_valid_i = 1'b0;
    wb_we_i = 1'b1;
    wb_addr_i = 5'd8;
    wb_data_i = 32'h88;
    #1;
    total++;
    if (issue_ready_o !== 1'b1)
      $display("FAIL sb_ready_retire got %b exp 1", issue_ready_o);
    else passed++;
    cyc();
    wb_we_i = 1'b0;
    #1;
    total++;
    if (issue_ready_o !== 1'b1 || reg1_busy_o !== 1'b1)
      $display("FAIL sb_pend2 got %b/%b exp 1/1",
               issue_ready_o, reg1_busy_o);
    else passed++;
    wb_we_i = 1'b1;
    cyc();
    wb_we_i = 1'b0;
    #1;
    total++;
    if (reg1_busy_o !== 1'b1)
      $display("FAIL sb_pend1 got %b exp 1", reg1_busy_o);
    else passed++;
    wb_we_i = 1'b1;
    cyc();
    wb_we_i = 1'b0;
    #1;
    total++;
    if (reg1_busy_o !== 1'b0 || stall_o !== 1'b0 || err_o !== 1'b0)
      $display("FAIL sb_drain got %b/%b/%b exp 0/0/0",
               reg1_busy_o, stall_o, err_o);
    else passed++;
    total++;
    if (reg1_data_o !== 32'h88)
      $display("FAIL sb_data got %h exp 88", reg1_data_o);
    else passed++;
  endtask

  task automatic test_bypass();
    issue_addr_i = 5'd3;
    issue_valid_i = 1'b1;
    cyc();
    issue_valid_i = 1'b0;
    wb_we_i = 1'b1;
    wb_addr_i = 5'd3;
    wb_data_i = 32'h11111111;
    cyc();
    wb_we_i = 1'b0;
    issue_valid_i = 1'b1;
    cyc();
    issue_valid_i = 1'b0;
    reg2_read_i = 1'b1;
    reg2_addr_i = 5'd3;
    wb_we_i = 1'b1;
    wb_data_i = 32'hA5A5A5A5;
    #1;
`ifdef REGFILE_BYPASS_EN
    total++;
    if (reg2_data_o !== 32'hA5A5A5A5 || reg2_busy_o !== 1'b0)
      $display("FAIL byp_same got %h/%b exp a5a5a5a5/0",
               reg2_data_o, reg2_busy_o);
    else passed++;
`else
    total++;
    if (reg2_data_o !== 32'h11111111 || reg2_busy_o !== 1'b1)
      $display("FAIL byp_same got %h/%b exp 11111111/1",
               reg2_data_o, reg2_busy_o);
    else passed++;
`endif
    cyc();
    wb_we_i = 1'b0;
    #1;
    total++;
    if (reg2_data_o !== 32'hA5A5A5A5 || reg2_busy_o !== 1'b0)
      $display("FAIL byp_next got %h/%b exp a5a5a5a5/0",
               reg2_data_o, reg2_busy_o);
    else passed++;
    reg2_read_i = 1'b0;
  endtask

  task automatic test_collision();
    issue_addr_i = 5'd9;
    issue_valid_i = 1'b1;
    cyc();
    wb_we_i = 1'b1;
    wb_addr_i = 5'd9;
    wb_data_i = 32'h99;
    #1;
    total++;
    if (issue_ready_o !== 1'b1)
      $display("FAIL col_ready got %b exp 1", issue_ready_o);
    else passed++;
    cyc();
    issue_valid_i = 1'b0;
    wb_we_i = 1'b0;
    reg1_addr_i = 5'd9;
    #1;
    total++;
    if (reg1_busy_o !== 1'b1 || reg1_data_o !== 32'h99)
      $display("FAIL col_state got %b/%h exp 1/99",
               reg1_busy_o, reg1_data_o);
    else passed++;
    total++;
    if (err_o !== 1'b0)
      $display("FAIL col_err got %b exp 0", err_o);
    else passed++;
    issue_addr_i = 5'd12;
    issue_valid_i = 1'b1;
    wb_we_i = 1'b1;
    wb_data_i = 32'h9A;
    cyc();
    issue_valid_i = 1'b0;
    wb_we_i = 1'b0;
    reg2_read_i = 1'b1;
    reg2_addr_i = 5'd12;
    #1;
    total++;
    if (reg1_busy_o !== 1'b0 || reg1_data_o !== 32'h9A ||
        reg2_busy_o !== 1'b1)
      $display("FAIL col_split got %b/%h/%b exp 0/9a/1",
               reg1_busy_o, reg1_data_o, reg2_busy_o);
    else passed++;
    wb_we_i = 1'b1;
    wb_addr_i = 5'd12;
    cyc();
    wb_we_i = 1'b0;
    reg2_read_i = 1'b0;
  endtask

  task automatic test_error();
    wb_we_i = 1'b1;
    wb_addr_i = 5'd10;
    wb_data_i = 32'h1;
    cyc();
    wb_we_i = 1'b0;
    #1;
    total++;
    if (err_o !== 1'b1)
      $display("FAIL err_set got %b exp 1", err_o);
    else passed++;
    cyc();
    total++;
    if (err_o !== 1'b1)
      $display("FAIL err_sticky got %b exp 1", err_o);
    else passed++;
    issue_addr_i = 5'd4;
    issue_valid_i = 1'b1;
    cyc();
    cyc();
    issue_valid_i = 1'b0;
    reg1_addr_i = 5'd4;
    #1;
    total++;
    if (reg1_busy_o !== 1'b1)
      $display("FAIL err_pend4 got %b exp 1", reg1_busy_o);
    else passed++;
    rst = 1'b1;
    #1;
    total++;
    if (issue_ready_o !== 1'b0 || reg1_busy_o !== 1'b0 ||
        stall_o !== 1'b0)
      $display("FAIL mid_rst got %b/%b/%b exp 0/0/0",
               issue_ready_o, reg1_busy_o, stall_o);
    else passed++;
    cyc();
    rst = 1'b0;
    reg2_read_i = 1'b1;
    reg2_addr_i = 5'd5;
    #1;
    total++;
    if (err_o !== 1'b0 || reg1_busy_o !== 1'b0 ||
        reg1_data_o !== 32'h0 || reg2_data_o !== 32'h0)
      $display("FAIL post_mid_rst got %b/%b/%h/%h exp 0/0/0/0",
               err_o, reg1_busy_o, reg1_data_o, reg2_data_o);
    else passed++;
    issue_valid_i = 1'b1;
    for (int k = 0; k < 3; k++) begin
      #1;
      total++;
      if (issue_ready_o !== 1'b1)
        $display("FAIL rst_pend_clr%0d got %b exp 1", k, issue_ready_o);
      else passed++;
      cyc();
    end
    issue_valid_i = 1'b0;
    reg2_read_i = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog expired");
    $fatal(1, "timeout");
  end

  initial begin
    rst = 1'b1;
    reg1_read_i = 1'b0;
    reg1_addr_i = 5'd0;
    reg2_read_i = 1'b0;
    reg2_addr_i = 5'd0;
    issue_valid_i = 1'b0;
    issue_addr_i = 5'd0;
    wb_we_i = 1'b0;
    wb_addr_i = 5'd0;
    wb_data_i = 32'h0;
    test_reset();
    test_write_read();
    test_scoreboard();
    test_bypass();
    test_collision();
    test_error();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
